// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared word type and switch FSM states
package hamming_pkg;

  localparam int WORD_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    S_STABLE = 1'b0,
    S_COUNT  = 1'b1
  } sw_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1 <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/module_switches.sv
// rtl/module_switches.sv - switch synchronizer, word debouncer and valid/ready output
module module_switches
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] sw_n,
  output logic [WORD_W-1:0] binario,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  localparam int    CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam word_t INACTIVE = ACTIVE_LOW ? {WORD_W{1'b1}} : {WORD_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic word_t pol(input word_t x);
    return ACTIVE_LOW ? ~x : x;
  endfunction

  word_t            sync_word;
  word_t            cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  sw_state_t        state, state_nxt;
  logic             commit;
  logic             accept;
  word_t            committed_raw;

  sync_2ff #(
    .WIDTH   (WORD_W),
    .RST_VAL (INACTIVE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_n),
    .q     (sync_word)
  );

  assign committed_raw = pol(binario);
  assign accept        = valid && ready;

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      S_STABLE: begin
        if (sync_word != committed_raw) begin
          cand_nxt  = sync_word;
          cnt_nxt   = '0;
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (sync_word == committed_raw) begin
          state_nxt = S_STABLE;
        end else if (sync_word != cand) begin
          // Any change of any bit restarts the whole word's settle time.
          cand_nxt = sync_word;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = S_STABLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_STABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_STABLE;
      cand    <= INACTIVE;
      cnt     <= '0;
      binario <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      cnt     <= cnt_nxt;
      // A commit coinciding with an accept hands over cleanly: no overrun.
      overrun <= commit && valid && !accept;
      if (commit) begin
        binario <= pol(cand);
        valid   <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_switches.sv
// tb/tb_module_switches.sv - directed self-checking bench for module_switches
module tb_module_switches;
  import hamming_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_n;
  logic [3:0] binario;
  logic       valid;
  logic       ready;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  module_switches #(
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_n    (sw_n),
    .binario (binario),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a raw word, let it commit, then accept it.
  task automatic settle(input logic [3:0] raw, input logic [3:0] exp_bin);
    sw_n = raw;
    repeat (12) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (binario !== exp_bin || valid !== 1'b0) begin
      failures++;
      $display("FAIL settle: binario=%b valid=%b required binario=%b valid=0", binario, valid, exp_bin);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_n = 4'b1111; ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (binario !== 4'b0000 || valid !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: binario=%b valid=%b overrun=%b required 0000/0/0", i, binario, valid, overrun);
      end
    end
    sw_n = 4'b1010;
    repeat (6) tick();
    checks++;
    if (dut.state !== S_COUNT) begin
      failures++;
      $display("FAIL reset_precount: state=%0d required S_COUNT", dut.state);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut.state !== S_STABLE || dut.cnt !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_midcount: state=%0d cnt=%0d valid=%b required S_STABLE/0/0", dut.state, dut.cnt, valid);
    end
    sw_n = 4'b1111;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_step();
    sw_n = 4'b1010;
    for (int e = 1; e <= 11; e++) begin
      tick();
      checks++;
      if (e < 11 && valid !== 1'b0) begin
        failures++;
        $display("FAIL clean_early edge%0d: valid=%b required 0", e, valid);
      end else if (e == 11 && (valid !== 1'b1 || binario !== 4'b0101)) begin
        failures++;
        $display("FAIL clean_commit edge11: valid=%b binario=%b required 1/0101", valid, binario);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    settle(4'b1111, 4'b0000);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 6; k++) begin
      sw_n = (k % 2 == 0) ? 4'b1110 : 4'b1111;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (valid !== 1'b0 || binario !== 4'b0000) begin
          failures++;
          $display("FAIL bounce_nocommit k%0d: valid=%b binario=%b required 0/0000", k, valid, binario);
        end
      end
    end
    sw_n = 4'b1110;
    for (int e = 1; e <= 11; e++) begin
      tick();
      checks++;
      if (e < 11 && valid !== 1'b0) begin
        failures++;
        $display("FAIL bounce_early edge%0d: valid=%b required 0", e, valid);
      end else if (e == 11 && (valid !== 1'b1 || binario !== 4'b0001)) begin
        failures++;
        $display("FAIL bounce_commit: valid=%b binario=%b required 1/0001", valid, binario);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    settle(4'b1111, 4'b0000);
  endtask

  task automatic test_glitch();
    sw_n = 4'b0111;
    repeat (5) tick();
    sw_n = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || binario !== 4'b0000) begin
        failures++;
        $display("FAIL glitch_nocommit cyc%0d: valid=%b binario=%b required 0/0000", i, valid, binario);
      end
    end
    checks++;
    if (dut.state !== S_STABLE) begin
      failures++;
      $display("FAIL glitch_state: state=%0d required S_STABLE", dut.state);
    end
  endtask

  task automatic test_handshake();
    sw_n = 4'b1100;
    repeat (11) tick();
    checks++;
    if (valid !== 1'b1 || binario !== 4'b0011) begin
      failures++;
      $display("FAIL hs_commit: valid=%b binario=%b required 1/0011", valid, binario);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1) begin
        failures++;
        $display("FAIL hs_hold cyc%0d: valid=%b required 1", i, valid);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || binario !== 4'b0011) begin
      failures++;
      $display("FAIL hs_accept: valid=%b binario=%b required 0/0011", valid, binario);
    end
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || binario !== 4'b0011) begin
      failures++;
      $display("FAIL hs_idle_ready: valid=%b binario=%b required 0/0011", valid, binario);
    end
  endtask

  task automatic test_overrun();
    sw_n = 4'b1110;
    repeat (11) tick();
    checks++;
    if (valid !== 1'b1 || binario !== 4'b0001 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first: valid=%b binario=%b overrun=%b required 1/0001/0", valid, binario, overrun);
    end
    sw_n = 4'b1101;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (overrun !== 1'b0) begin
        failures++;
        $display("FAIL ovr_early edge%0d: overrun=%b required 0", e, overrun);
      end
    end
    tick();
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b1 || binario !== 4'b0010) begin
      failures++;
      $display("FAIL ovr_pulse: overrun=%b valid=%b binario=%b required 1/1/0010", overrun, valid, binario);
    end
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_width: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    sw_n = 4'b1110;
    repeat (10) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (overrun !== 1'b0 || valid !== 1'b1 || binario !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_commit_accept: overrun=%b valid=%b binario=%b required 0/1/0001", overrun, valid, binario);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_after: overrun=%b valid=%b required 0/1", overrun, valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_handshake();
    test_overrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
